// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter: both upstream request/response channels and the downstream port.
// The arbiter binds the slave modport; the requester/memory side binds the master modport.
interface ysyx_25030093_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_req_addr;
    logic                  ifu_rsp_valid;
    logic                  ifu_rsp_ready;
    logic [DATA_W-1:0]     ifu_rsp_data;
    logic                  ifu_rsp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_W-1:0]     lsu_req_wdata;
    logic [DATA_W/8-1:0]   lsu_req_wstrb;
    logic                  lsu_rsp_valid;
    logic                  lsu_rsp_ready;
    logic [DATA_W-1:0]     lsu_rsp_rdata;
    logic                  lsu_rsp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wstrb;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DATA_W-1:0]     mem_rsp_rdata;
    logic                  mem_rsp_err;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb, lsu_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_rsp_ready
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb, lsu_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_rsp_ready
    );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU, with a response watchdog.
// ARB_RR_EN selects round-robin tie-breaking; otherwise LSU has fixed priority over IFU.
module ysyx_25030093_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_25030093_mem_arbiter_if.slave bus,
    output logic                       busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_TOUT} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_ifu, grant_lsu;
    logic                owner_rdy;
`ifdef ARB_RR_EN
    logic                last_lsu_q, last_lsu_d;
`endif

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
`ifdef ARB_RR_EN
        // On a tie the side not granted last time wins.
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            grant_ifu = last_lsu_q;
            grant_lsu = !last_lsu_q;
        end else begin
            grant_ifu = bus.ifu_req_valid;
            grant_lsu = bus.lsu_req_valid;
        end
`else
        grant_lsu = bus.lsu_req_valid;
        grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
`endif
    end

    assign owner_rdy = (owner_q == OWN_LSU) ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
`ifdef ARB_RR_EN
        last_lsu_d = last_lsu_q;
`endif
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_data  = '0;
        bus.ifu_rsp_err   = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_rdata = '0;
        bus.lsu_rsp_err   = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_rsp_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Drain any late response left over from a timed-out transaction.
                bus.mem_rsp_ready = 1'b1;
                bus.ifu_req_ready = grant_ifu;
                bus.lsu_req_ready = grant_lsu;
                if (grant_lsu) begin
                    addr_d  = bus.lsu_req_addr;
                    wen_d   = bus.lsu_req_wen;
                    wdata_d = bus.lsu_req_wdata;
                    wstrb_d = bus.lsu_req_wstrb;
                    owner_d = OWN_LSU;
                    state_d = S_REQ;
                end else if (grant_ifu) begin
                    addr_d  = bus.ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    owner_d = OWN_IFU;
                    state_d = S_REQ;
                end
`ifdef ARB_RR_EN
                if (grant_lsu || grant_ifu) last_lsu_d = grant_lsu;
`endif
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = S_RSP;
                    cnt_d   = '0;
                end
            end
            S_RSP: begin
                bus.mem_rsp_ready = owner_rdy;
                if (owner_q == OWN_LSU) begin
                    bus.lsu_rsp_valid = bus.mem_rsp_valid;
                    bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
                    bus.lsu_rsp_err   = bus.mem_rsp_err;
                end else begin
                    bus.ifu_rsp_valid = bus.mem_rsp_valid;
                    bus.ifu_rsp_data  = bus.mem_rsp_rdata;
                    bus.ifu_rsp_err   = bus.mem_rsp_err;
                end
                if (bus.mem_rsp_valid && owner_rdy) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end else if (!bus.mem_rsp_valid && (TIMEOUT_CYC != 0)) begin
                    // Counter saturates at the limit; the state change fires on the cycle that reaches it.
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= CNT_MAX - 1'b1) state_d = S_TOUT;
                end
            end
            S_TOUT: begin
                if (owner_q == OWN_LSU) begin
                    bus.lsu_rsp_valid = 1'b1;
                    bus.lsu_rsp_err   = 1'b1;
                end else begin
                    bus.ifu_rsp_valid = 1'b1;
                    bus.ifu_rsp_err   = 1'b1;
                end
                if (owner_rdy) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
`ifdef ARB_RR_EN
            last_lsu_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
`ifdef ARB_RR_EN
            last_lsu_q <= last_lsu_d;
`endif
        end
    end

    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wstrb = wstrb_q;
    assign busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: random IFU/LSU traffic, random memory latency and dropped responses.
// Arbitration, busy and response routing are predicted from the transaction-level rules, not from DUT state.
module tb_ysyx_25030093_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TMO = 8;
    localparam int N_TXN = 60;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    ysyx_25030093_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_25030093_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit              is_lsu;
        logic [AW-1:0]   addr;
        logic            wen;
        logic [DW-1:0]   wdata;
        logic [SW-1:0]   wstrb;
    } req_t;

    logic [DW:0] exp_ifu[$];
    logic [DW:0] exp_lsu[$];
    req_t        grants[$];

    bit mon_en = 0, stim_done = 0;
    bit outstanding = 0, cur_lsu = 0, acc_prev = 0, last_lsu = 1;
    bit ifu_hold = 0, lsu_hold = 0;
    logic [DW:0] ifu_hold_v, lsu_hold_v;

    function automatic logic owner_valid(input bit is_lsu);
        return is_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid;
    endfunction

    function automatic logic owner_ready(input bit is_lsu);
        return is_lsu ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
    endfunction

    // Transaction-level monitor: arbitration rule, busy, routing, backpressure and scoreboard compare.
    always @(negedge clk) begin
        if (mon_en) begin
            bit was_out, ei, el;
            was_out = outstanding;
            chk("busy", 64'(busy), 64'(was_out));
            if (!was_out) begin
                ei = bus.ifu_req_valid;
                el = bus.lsu_req_valid;
                if (ei && el) begin
`ifdef ARB_RR_EN
                    ei = last_lsu;
                    el = !last_lsu;
`else
                    ei = 1'b0;
`endif
                end
                chk("ifu_req_ready", 64'(bus.ifu_req_ready), 64'(ei));
                chk("lsu_req_ready", 64'(bus.lsu_req_ready), 64'(el));
                chk("idle_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(1));
                chk("idle_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
                chk("idle_rsp_valids", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'(0));
            end else begin
                chk("busy_req_ready", 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'(0));
                chk("non_owner_rsp_valid", 64'(owner_valid(!cur_lsu)), 64'(0));
                if (owner_valid(cur_lsu) && !owner_ready(cur_lsu))
                    chk("backpressure_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(0));
            end
            if (acc_prev) chk("mem_req_valid_after_grant", 64'(bus.mem_req_valid), 64'(1));
            acc_prev = 0;

            if (ifu_hold) chk("ifu_rsp_hold", 64'({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data}),
                              64'({1'b1, ifu_hold_v}));
            if (lsu_hold) chk("lsu_rsp_hold", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rsp_rdata}),
                              64'({1'b1, lsu_hold_v}));
            ifu_hold = bus.ifu_rsp_valid && !bus.ifu_rsp_ready;
            lsu_hold = bus.lsu_rsp_valid && !bus.lsu_rsp_ready;
            ifu_hold_v = {bus.ifu_rsp_err, bus.ifu_rsp_data};
            lsu_hold_v = {bus.lsu_rsp_err, bus.lsu_rsp_rdata};

            if (bus.ifu_rsp_valid && bus.ifu_rsp_ready) begin
                chk("ifu_rsp_expected", 64'(exp_ifu.size() != 0), 64'(1));
                if (exp_ifu.size() != 0)
                    chk("ifu_rsp", 64'({bus.ifu_rsp_err, bus.ifu_rsp_data}), 64'(exp_ifu.pop_front()));
                if (was_out && !cur_lsu) outstanding = 0;
            end
            if (bus.lsu_rsp_valid && bus.lsu_rsp_ready) begin
                chk("lsu_rsp_expected", 64'(exp_lsu.size() != 0), 64'(1));
                if (exp_lsu.size() != 0)
                    chk("lsu_rsp", 64'({bus.lsu_rsp_err, bus.lsu_rsp_rdata}), 64'(exp_lsu.pop_front()));
                if (was_out && cur_lsu) outstanding = 0;
            end

            if (!was_out) begin
                req_t g;
                if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                    g.is_lsu = 1; g.addr = bus.lsu_req_addr; g.wen = bus.lsu_req_wen;
                    g.wdata = bus.lsu_req_wdata; g.wstrb = bus.lsu_req_wstrb;
                    grants.push_back(g);
                    outstanding = 1; acc_prev = 1; cur_lsu = 1; last_lsu = 1;
                end else if (bus.ifu_req_valid && bus.ifu_req_ready) begin
                    g.is_lsu = 0; g.addr = bus.ifu_req_addr; g.wen = 1'b0; g.wdata = '0; g.wstrb = '0;
                    grants.push_back(g);
                    outstanding = 1; acc_prev = 1; cur_lsu = 0; last_lsu = 0;
                end
            end
        end
    end

    task automatic requester(input bit is_lsu);
        for (int i = 0; i < N_TXN; i++) begin
            bit acc;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if (is_lsu) begin
                bus.lsu_req_addr  = $urandom & 32'hFFFF_FFFC;
                bus.lsu_req_wen   = 1'($urandom_range(0, 1));
                bus.lsu_req_wdata = $urandom;
                bus.lsu_req_wstrb = 4'($urandom_range(0, 15));
                bus.lsu_req_valid = 1'b1;
            end else begin
                bus.ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
                bus.ifu_req_valid = 1'b1;
            end
            acc = 0;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk);
                if (is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready) begin acc = 1; break; end
            end
            chk(is_lsu ? "lsu_req_accepted" : "ifu_req_accepted", 64'(acc), 64'(1));
            @(posedge clk); #1;
            if (is_lsu) bus.lsu_req_valid = 1'b0; else bus.ifu_req_valid = 1'b0;
        end
    endtask

    task automatic rsp_ready_drv();
        while (!stim_done) begin
            @(posedge clk); #1;
            bus.ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            bus.lsu_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Memory model: random accept stalls, random latency, occasional lost response followed by a late one.
    task automatic mem_model();
        forever begin
            req_t g;
            bit got, hs;
            got = 0; hs = 0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (bus.mem_req_valid) begin
                    if (!got) begin
                        got = 1;
                        chk("mem_req_has_grant", 64'(grants.size() != 0), 64'(1));
                        if (grants.size() != 0) g = grants.pop_front();
                    end
                    chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(g.addr));
                    chk("mem_req_wen", 64'(bus.mem_req_wen), 64'(g.wen));
                    chk("mem_req_wstrb", 64'(bus.mem_req_wstrb), 64'(g.wstrb));
                    if (g.is_lsu) chk("mem_req_wdata", 64'(bus.mem_req_wdata), 64'(g.wdata));
                    if (bus.mem_req_ready) begin hs = 1; break; end
                end else if (stim_done) begin
                    break;
                end
                @(posedge clk); #1;
                bus.mem_req_ready = ($urandom_range(0, 2) != 0);
            end
            if (!got) return;
            chk("mem_req_handshake", 64'(hs), 64'(1));
            @(posedge clk); #1;
            bus.mem_req_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                if (g.is_lsu) exp_lsu.push_back({1'b1, 32'h0}); else exp_ifu.push_back({1'b1, 32'h0});
                for (int k = 1; k <= TMO; k++) begin
                    @(negedge clk);
                    chk("tout_not_early", 64'(owner_valid(g.is_lsu)), 64'(0));
                end
                @(negedge clk);
                chk("tout_rsp_valid", 64'(owner_valid(g.is_lsu)), 64'(1));
                hs = owner_valid(g.is_lsu) && owner_ready(g.is_lsu);
                for (int t = 0; t < 200 && !hs; t++) begin
                    @(negedge clk);
                    hs = owner_valid(g.is_lsu) && owner_ready(g.is_lsu);
                end
                chk("tout_rsp_taken", 64'(hs), 64'(1));
                @(posedge clk); #1;
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = $urandom;
                bus.mem_rsp_err   = 1'b1;
                @(negedge clk);
                chk("late_rsp_drained", 64'(bus.mem_rsp_ready), 64'(1));
                chk("late_rsp_not_fwd", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'(0));
                @(posedge clk); #1;
                bus.mem_rsp_valid = 1'b0;
            end else begin
                logic [DW-1:0] d;
                logic          e;
                repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                d = $urandom;
                e = ($urandom_range(0, 7) == 0);
                if (g.is_lsu) exp_lsu.push_back({e, d}); else exp_ifu.push_back({e, d});
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = d;
                bus.mem_rsp_err   = e;
                hs = 0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (bus.mem_rsp_ready) begin hs = 1; break; end
                end
                chk("mem_rsp_taken", 64'(hs), 64'(1));
                @(posedge clk); #1;
                bus.mem_rsp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        bit drained;
        rst = 1'b1;
        bus.ifu_req_valid = 0; bus.ifu_req_addr = '0; bus.ifu_rsp_ready = 0;
        bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
        bus.lsu_req_wdata = '0; bus.lsu_req_wstrb = '0; bus.lsu_rsp_ready = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("rst_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(1));
        chk("rst_rsp_valids", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'(0));
        chk("rst_mem_req_fields", 64'({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wstrb}), 64'(0));

        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0000;
        bus.ifu_req_valid = 1'b1;
        @(negedge clk);
        chk("dir_ifu_req_ready", 64'(bus.ifu_req_ready), 64'(1));
        chk("dir_busy_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("dir_mem_req_valid", 64'(bus.mem_req_valid), 64'(1));
        chk("dir_mem_req_addr", 64'(bus.mem_req_addr), 64'(32'h8000_0000));
        chk("dir_mem_req_wen", 64'({bus.mem_req_wen, bus.mem_req_wstrb}), 64'(0));
        @(negedge clk);
        chk("dir_mem_req_one_cycle", 64'(bus.mem_req_valid), 64'(0));
        chk("dir_busy_rsp", 64'(busy), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_rsp_busy", 64'(busy), 64'(0));
        chk("rst_in_rsp_valids", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid}), 64'(0));
        chk("rst_in_rsp_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_req_ready = 1'b0;

        mon_en = 1;
        fork
            mem_model();
            rsp_ready_drv();
        join_none
        fork
            requester(1'b0);
            requester(1'b1);
        join

        drained = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!outstanding && exp_ifu.size() == 0 && exp_lsu.size() == 0 && grants.size() == 0) begin
                drained = 1;
                break;
            end
        end
        chk("all_responses_returned", 64'(drained), 64'(1));
        stim_done = 1;
        repeat (5) @(posedge clk);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete at %0t", $time);
        $fatal(1);
    end
endmodule
